// File: rtl/if_fetch_block.sv
// ----------------------------------------------------------------------------
// if_fetch_block
// Instruction-fetch stage feeding dependency-check/decode. Holds the PC,
// reads an asynchronous-read instruction ROM, resolves unconditional jumps
// locally, inserts one NOP bubble after every load and stalls with NOPs after
// a conditional jump until execute reports the branch outcome.
//
// Ports:
//   clk        - clock, all state updates on rising edge
//   reset      - asynchronous active-low reset
//   imem_addr  - ROM word address (combinationally equal to pc)
//   imem_data  - ROM word at imem_addr, valid in the same cycle
//   br_valid   - execute reports the conditional-jump outcome this cycle
//   br_taken   - branch outcome, qualified by br_valid
//   br_target  - branch target word address
//   hold       - freeze the whole stage this cycle
//   ins        - registered instruction to decode
//   ins_pc     - word address of the instruction in ins
//   br_pending - high while waiting for a branch outcome
//   issue_cnt  - count of non-NOP words issued into ins (wraps)
// ----------------------------------------------------------------------------
module if_fetch_block #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_data,
   input  logic              br_valid,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              hold,
   output logic [31:0]       ins,
   output logic [ADDR_W-1:0] ins_pc,
   output logic              br_pending,
   output logic [CNT_W-1:0]  issue_cnt
);

   localparam int unsigned INS_W = 32;
   localparam logic [INS_W-1:0] NOP = '0;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LD_HOLD = 2'd1,
      BR_WAIT = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INS_W-1:0]   ins_q, ins_d;
   logic [ADDR_W-1:0]  ins_pc_q, ins_pc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // Opcode decode of the fetched word
   logic is_jmp, is_cj, is_ld;
   assign is_jmp = (imem_data[31:26] == 6'b011000);
   assign is_cj  = (imem_data[31:28] == 4'b0111);
   assign is_ld  = (imem_data[31:26] == 6'b010100);

   // State and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= RUN;
         pc_q     <= '0;
         ins_q    <= NOP;
         ins_pc_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ins_q    <= ins_d;
         ins_pc_q <= ins_pc_d;
         cnt_q    <= cnt_d;
      end
   end

   // Next-state and datapath update; hold keeps everything as is
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ins_d    = ins_q;
      ins_pc_d = ins_pc_q;
      cnt_d    = cnt_q;

      if (!hold) begin
         // ins_pc tracks the pc of every load into ins, bubbles included
         ins_pc_d = pc_q;
         case (state_q)
            RUN: begin
               ins_d = imem_data;
               pc_d  = pc_q + ADDR_W'(1);
               if (imem_data != NOP) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               if (is_jmp) begin
                  // Absolute word target; upper opcode/field bits ignored
                  pc_d = imem_data[ADDR_W-1:0];
               end else if (is_ld) begin
                  state_d = LD_HOLD;
               end else if (is_cj) begin
                  state_d = BR_WAIT;
               end
            end
            LD_HOLD: begin
               ins_d   = NOP;
               state_d = RUN;
            end
            BR_WAIT: begin
               // pc already holds the fall-through address
               ins_d = NOP;
               if (br_valid) begin
                  state_d = RUN;
                  if (br_taken) begin
                     pc_d = br_target;
                  end
               end
            end
            default: begin
               ins_d   = NOP;
               state_d = RUN;
            end
         endcase
      end
   end

   assign imem_addr  = pc_q;
   assign ins        = ins_q;
   assign ins_pc     = ins_pc_q;
   assign issue_cnt  = cnt_q;
   assign br_pending = (state_q == BR_WAIT);

endmodule

// File: tb/tb_if_fetch_block.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_block
// Directed bench for if_fetch_block: a behavioural ROM drives imem_data, an
// expected-output queue is filled as each stimulus step is set up and drained
// one entry per clock edge.
// ----------------------------------------------------------------------------
module tb_if_fetch_block;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned CNT_W  = 16;
   localparam logic [31:0] NOP    = 32'h0000_0000;
   localparam logic [31:0] LD_W   = 32'h5000_0000;
   localparam logic [31:0] CJ_W   = 32'h7000_0000;

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_data;
   logic              br_valid;
   logic              br_taken;
   logic [ADDR_W-1:0] br_target;
   logic              hold;
   logic [31:0]       ins;
   logic [ADDR_W-1:0] ins_pc;
   logic              br_pending;
   logic [CNT_W-1:0]  issue_cnt;

   logic [31:0] rom [256];

   typedef struct {
      logic [31:0]       ins;
      logic [ADDR_W-1:0] pc;
      logic              bp;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   assign imem_data = rom[imem_addr];

   if_fetch_block #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .br_valid   (br_valid),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .hold       (hold),
      .ins        (ins),
      .ins_pc     (ins_pc),
      .br_pending (br_pending),
      .issue_cnt  (issue_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] i, input int p, input logic b);
      exp_t e;
      e.ins = i;
      e.pc  = ADDR_W'(p);
      e.bp  = b;
      sb.push_back(e);
   endtask

   // Advance n edges, comparing DUT outputs against the queue each edge
   task automatic run(input int n, input string tag);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s[%0d] scoreboard empty: observed ins %h expected an entry", tag, k, ins);
         end else begin
            e = sb.pop_front();
            chk($sformatf("%s[%0d] ins", tag, k), ins, e.ins);
            chk($sformatf("%s[%0d] ins_pc", tag, k), 32'(ins_pc), 32'(e.pc));
            chk($sformatf("%s[%0d] br_pending", tag, k), 32'(br_pending), 32'(e.bp));
         end
      end
   endtask

   task automatic rom_default();
      for (int i = 0; i < 256; i++) rom[i] = 32'h0100_0000 | 32'(i);
      rom[0] = 32'h0400_0001;
      rom[1] = 32'h0800_0002;
      rom[2] = 32'h0C00_0003;
      rom[3] = 32'h1000_0004;
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      hold      = 1'b0;
      br_valid  = 1'b0;
      br_taken  = 1'b0;
      br_target = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      rom_default();

      // 1: plain sequential fetch
      do_reset();
      chk("rst ins", ins, NOP);
      chk("rst ins_pc", 32'(ins_pc), 32'd0);
      chk("rst br_pending", 32'(br_pending), 32'd0);
      chk("rst issue_cnt", 32'(issue_cnt), 32'd0);
      chk("rst imem_addr", 32'(imem_addr), 32'd0);
      push(32'h0400_0001, 0, 1'b0);
      push(32'h0800_0002, 1, 1'b0);
      push(32'h0C00_0003, 2, 1'b0);
      push(32'h1000_0004, 3, 1'b0);
      run(4, "seq");
      chk("seq issue_cnt", 32'(issue_cnt), 32'd4);

      // 2: load bubble; stray br_valid in RUN/LD_HOLD must be ignored
      rom[2] = LD_W;
      do_reset();
      br_valid  = 1'b1;
      br_taken  = 1'b1;
      br_target = 8'h30;
      push(32'h0400_0001, 0, 1'b0);
      push(32'h0800_0002, 1, 1'b0);
      push(LD_W,          2, 1'b0);
      push(NOP,           3, 1'b0);
      push(32'h1000_0004, 3, 1'b0);
      run(5, "ld");
      chk("ld issue_cnt", 32'(issue_cnt), 32'd4);
      br_valid = 1'b0;
      rom_default();

      // 3: unconditional jump to 0x40
      rom[1] = 32'h6000_0040;
      do_reset();
      push(32'h0400_0001, 0,     1'b0);
      push(32'h6000_0040, 1,     1'b0);
      push(32'h0100_0040, 8'h40, 1'b0);
      push(32'h0100_0041, 8'h41, 1'b0);
      run(4, "jmp");
      chk("jmp issue_cnt", 32'(issue_cnt), 32'd4);
      rom_default();

      // 4a: conditional jump, taken on third BR_WAIT cycle
      rom[5] = CJ_W;
      do_reset();
      push(32'h0400_0001, 0, 1'b0);
      push(32'h0800_0002, 1, 1'b0);
      push(32'h0C00_0003, 2, 1'b0);
      push(32'h1000_0004, 3, 1'b0);
      push(32'h0100_0004, 4, 1'b0);
      push(CJ_W,          5, 1'b1);
      push(NOP,           6, 1'b1);
      push(NOP,           6, 1'b1);
      run(8, "cjt");
      br_valid  = 1'b1;
      br_taken  = 1'b1;
      br_target = 8'h20;
      push(NOP, 6, 1'b0);
      run(1, "cjt_res");
      br_valid = 1'b0;
      push(32'h0100_0020, 8'h20, 1'b0);
      run(1, "cjt_tgt");
      chk("cjt issue_cnt", 32'(issue_cnt), 32'd7);

      // 4b: same, not taken
      do_reset();
      push(32'h0400_0001, 0, 1'b0);
      push(32'h0800_0002, 1, 1'b0);
      push(32'h0C00_0003, 2, 1'b0);
      push(32'h1000_0004, 3, 1'b0);
      push(32'h0100_0004, 4, 1'b0);
      push(CJ_W,          5, 1'b1);
      push(NOP,           6, 1'b1);
      push(NOP,           6, 1'b1);
      run(8, "cjn");
      br_valid  = 1'b1;
      br_taken  = 1'b0;
      br_target = 8'h20;
      push(NOP, 6, 1'b0);
      run(1, "cjn_res");
      br_valid = 1'b0;
      push(32'h0100_0006, 6, 1'b0);
      run(1, "cjn_ft");
      chk("cjn issue_cnt", 32'(issue_cnt), 32'd7);

      // 5a: hold mid-RUN
      rom_default();
      do_reset();
      push(32'h0400_0001, 0, 1'b0);
      push(32'h0800_0002, 1, 1'b0);
      run(2, "hr_pre");
      hold = 1'b1;
      for (int k = 0; k < 4; k++) push(32'h0800_0002, 1, 1'b0);
      run(4, "hr_hold");
      chk("hr imem_addr", 32'(imem_addr), 32'd2);
      chk("hr issue_cnt", 32'(issue_cnt), 32'd2);
      hold = 1'b0;
      push(32'h0C00_0003, 2, 1'b0);
      push(32'h1000_0004, 3, 1'b0);
      run(2, "hr_post");

      // 5b: hold in BR_WAIT with a br_valid pulse that must be lost
      rom[5] = CJ_W;
      do_reset();
      push(32'h0400_0001, 0, 1'b0);
      push(32'h0800_0002, 1, 1'b0);
      push(32'h0C00_0003, 2, 1'b0);
      push(32'h1000_0004, 3, 1'b0);
      push(32'h0100_0004, 4, 1'b0);
      push(CJ_W,          5, 1'b1);
      run(6, "hb_pre");
      hold = 1'b1;
      for (int k = 0; k < 4; k++) push(CJ_W, 5, 1'b1);
      run(1, "hb_hold0");
      br_valid  = 1'b1;
      br_taken  = 1'b1;
      br_target = 8'h20;
      run(1, "hb_hold1");
      br_valid = 1'b0;
      run(2, "hb_hold2");
      chk("hb imem_addr", 32'(imem_addr), 32'd6);
      chk("hb issue_cnt", 32'(issue_cnt), 32'd6);
      hold = 1'b0;
      push(NOP, 6, 1'b1);
      push(NOP, 6, 1'b1);
      run(2, "hb_wait");
      br_valid = 1'b1;
      br_taken = 1'b0;
      push(NOP, 6, 1'b0);
      run(1, "hb_res");
      br_valid = 1'b0;
      push(32'h0100_0006, 6, 1'b0);
      run(1, "hb_ft");
      rom_default();

      // 6a: pc wraps from 0xFF to 0x00
      rom[1] = 32'h6000_00FE;
      do_reset();
      push(32'h0400_0001, 0,     1'b0);
      push(32'h6000_00FE, 1,     1'b0);
      push(32'h0100_00FE, 8'hFE, 1'b0);
      push(32'h0100_00FF, 8'hFF, 1'b0);
      run(4, "wrap");
      chk("wrap imem_addr", 32'(imem_addr), 32'd0);
      push(32'h0400_0001, 0, 1'b0);
      run(1, "wrap_post");
      rom_default();

      // 6b: asynchronous reset in BR_WAIT takes effect before the next edge
      rom[5] = CJ_W;
      do_reset();
      push(32'h0400_0001, 0, 1'b0);
      push(32'h0800_0002, 1, 1'b0);
      push(32'h0C00_0003, 2, 1'b0);
      push(32'h1000_0004, 3, 1'b0);
      push(32'h0100_0004, 4, 1'b0);
      push(CJ_W,          5, 1'b1);
      push(NOP,           6, 1'b1);
      run(7, "ar_pre");
      reset = 1'b0;
      #2;
      chk("ar ins", ins, NOP);
      chk("ar imem_addr", 32'(imem_addr), 32'd0);
      chk("ar ins_pc", 32'(ins_pc), 32'd0);
      chk("ar br_pending", 32'(br_pending), 32'd0);
      chk("ar issue_cnt", 32'(issue_cnt), 32'd0);
      do_reset();
      push(32'h0400_0001, 0, 1'b0);
      run(1, "ar_post");

      chk("sb drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
